// File: rtl/fetch_predict.sv
// Instruction-fetch stage: pre-decodes the fetched word, predicts the next PC from a
// 2-bit counter table, and loads the IF/ID register. A resolved mispredict redirects fetch.
module fetch_predict #(
    parameter int                PC_W        = 64,
    parameter int                BHT_ENTRIES = 16,
    parameter logic [PC_W-1:0]   RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      if_instr,
    output logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             if_valid,
    input  logic             resolve_valid,
    input  logic [PC_W-1:0]  resolve_pc,
    input  logic             resolve_taken,
    input  logic [PC_W-1:0]  resolve_target,
    input  logic             resolve_mispredict,
    output logic [31:0]      mispredict_count
);

    localparam int              IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
    localparam logic [1:0]      CTR_INIT = 2'b01;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [31:0] count_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [PC_W-1:0]         pc_p0;
    logic [1:0]              bht [BHT_ENTRIES];

    logic                    is_b_p0;
    logic                    is_cond_p0;
    logic signed [PC_W-1:0]  off_b_p0;
    logic signed [PC_W-1:0]  off_cond_p0;
    logic [PC_W-1:0]         target_p0;
    logic [PC_W-1:0]         seq_pc_p0;
    logic [PC_W-1:0]         pred_next_p0;
    logic                    pred_taken_p0;
    logic [IDX_W-1:0]        fetch_idx;
    logic [IDX_W-1:0]        resolve_idx;
    logic                    redirect;
    logic [PC_W-1:0]         redirect_pc;

    assign imem_addr = pc_p0;

    // Fetch stage (p0): pre-decode the returned word and form the predicted next PC
    assign is_b_p0     = (imem_data[31:26] == 6'b000101);
    assign is_cond_p0  = (imem_data[31:24] == 8'b0101_0100) || (imem_data[31:24] == 8'b1011_0100);
    assign off_b_p0    = {{(PC_W-28){imem_data[25]}}, imem_data[25:0], 2'b00};
    assign off_cond_p0 = {{(PC_W-21){imem_data[23]}}, imem_data[23:5], 2'b00};
    assign target_p0   = is_b_p0 ? (pc_p0 + off_b_p0) : (pc_p0 + off_cond_p0);
    assign seq_pc_p0   = pc_p0 + PC_STEP;

    assign fetch_idx     = pc_p0[IDX_W+1:2];
    assign resolve_idx   = resolve_pc[IDX_W+1:2];
    assign pred_taken_p0 = is_b_p0 | (is_cond_p0 & bht[fetch_idx][1]);
    assign pred_next_p0  = pred_taken_p0 ? target_p0 : seq_pc_p0;

    assign redirect    = resolve_valid & resolve_mispredict;
    assign redirect_pc = resolve_taken ? resolve_target : (resolve_pc + PC_STEP);

    // IF/ID boundary: PC, IF/ID register, predictor table and redirect counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0            <= RESET_PC;
            if_instr         <= '0;
            if_pc            <= '0;
            if_pred_taken    <= 1'b0;
            if_valid         <= 1'b0;
            mispredict_count <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else begin
            if (redirect) begin
                pc_p0            <= redirect_pc;
                if_valid         <= 1'b0;
                mispredict_count <= count_sat_inc(mispredict_count);
            end else if (!stall) begin
                pc_p0         <= pred_next_p0;
                if_instr      <= imem_data;
                if_pc         <= pc_p0;
                if_pred_taken <= pred_taken_p0;
                if_valid      <= 1'b1;
            end
            // Table update ignores stall; a same-cycle fetch lookup sees the old counter
            if (resolve_valid) begin
                bht[resolve_idx] <= resolve_taken ? ctr_inc(bht[resolve_idx])
                                                  : ctr_dec(bht[resolve_idx]);
            end
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed scenarios followed by random traffic, all compared
// against a behavioural next-PC / counter-table model.
module tb_fetch_predict;

    localparam int          PC_W   = 64;
    localparam int          BHT    = 16;
    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] NOP    = 32'hD503_201F;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_pred_taken;
    logic        if_valid;
    logic        resolve_valid;
    logic [63:0] resolve_pc;
    logic        resolve_taken;
    logic [63:0] resolve_target;
    logic        resolve_mispredict;
    logic [31:0] mispredict_count;

    fetch_predict #(.PC_W(PC_W), .BHT_ENTRIES(BHT), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_instr(if_instr), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_valid(if_valid),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_mispredict(resolve_mispredict),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_pc;
    int          m_bht [BHT];
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;
    logic        m_pred;
    logic        m_valid;
    logic        m_known;
    logic [31:0] m_cnt;

    function automatic logic [31:0] mk_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    function automatic logic [31:0] mk_bcond(input logic [18:0] imm);
        return {8'h54, imm, 5'd1};
    endfunction

    function automatic logic [31:0] mk_cbz(input logic [18:0] imm);
        return {8'hB4, imm, 5'd3};
    endfunction

    // Signed field value times four, as a 64-bit two's-complement offset
    function automatic logic [63:0] sext_off(input longint v, input int bits);
        longint r;
        r = v;
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return 64'(r * 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [63:0] nxt;
        logic        pt;
        int          fidx;
        int          ridx;
        if (reset) begin
            m_pc = RST_PC;
            for (int i = 0; i < BHT; i++) m_bht[i] = 1;
            m_instr = '0; m_ifpc = '0; m_pred = 1'b0; m_valid = 1'b0; m_known = 1'b1;
            m_cnt = '0;
        end else begin
            fidx = int'((m_pc >> 2) % 64'(BHT));
            pt   = 1'b0;
            nxt  = m_pc + 64'd4;
            if (imem_data[31:26] == 6'b000101) begin
                pt  = 1'b1;
                nxt = m_pc + sext_off(longint'(imem_data[25:0]), 26);
            end else if (imem_data[31:24] == 8'h54 || imem_data[31:24] == 8'hB4) begin
                pt = (m_bht[fidx] >= 2);
                if (pt) nxt = m_pc + sext_off(longint'(imem_data[23:5]), 19);
            end
            if (resolve_valid && resolve_mispredict) begin
                m_pc    = resolve_taken ? resolve_target : resolve_pc + 64'd4;
                m_valid = 1'b0;
                m_known = 1'b0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end else if (!stall) begin
                m_instr = imem_data;
                m_ifpc  = m_pc;
                m_pred  = pt;
                m_valid = 1'b1;
                m_known = 1'b1;
                m_pc    = nxt;
            end
            if (resolve_valid) begin
                ridx = int'((resolve_pc >> 2) % 64'(BHT));
                if (resolve_taken) m_bht[ridx] = (m_bht[ridx] < 3) ? m_bht[ridx] + 1 : 3;
                else               m_bht[ridx] = (m_bht[ridx] > 0) ? m_bht[ridx] - 1 : 0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 64'(if_valid), 64'(m_valid));
        check("mispredict_count", 64'(mispredict_count), 64'(m_cnt));
        if (m_known) begin
            check("if_instr", 64'(if_instr), 64'(m_instr));
            check("if_pc", if_pc, m_ifpc);
            check("if_pred_taken", 64'(if_pred_taken), 64'(m_pred));
        end
    endtask

    task automatic clear_resolve();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0; resolve_taken = 1'b0;
        resolve_pc = '0; resolve_target = '0;
    endtask

    task automatic resolve(input logic [63:0] pc, input logic taken);
        resolve_valid = 1'b1; resolve_mispredict = 1'b0;
        resolve_pc = pc; resolve_taken = taken; resolve_target = '0;
        cycle();
        clear_resolve();
    endtask

    // Taken mispredict from an index that the directed tests leave alone
    task automatic redirect_to(input logic [63:0] tgt);
        resolve_valid = 1'b1; resolve_mispredict = 1'b1;
        resolve_pc = 64'h2F0; resolve_taken = 1'b1; resolve_target = tgt;
        cycle();
        clear_resolve();
    endtask

    initial begin
        logic [31:0] rnd;
        reset = 1'b1; stall = 1'b0; imem_data = NOP;
        clear_resolve();

        // Reset and sequential fetch
        cycle();
        check("rst_addr", imem_addr, 64'h100);
        check("rst_cnt", 64'(mispredict_count), 64'd0);
        reset = 1'b0;
        cycle();
        check("seq_addr1", imem_addr, 64'h104);
        check("seq_ifpc1", if_pc, 64'h100);
        check("seq_valid1", 64'(if_valid), 64'd1);
        cycle();
        check("seq_addr2", imem_addr, 64'h108);

        // Unconditional branch backwards and wrap-around
        redirect_to(64'h200);
        check("redir_valid", 64'(if_valid), 64'd0);
        imem_data = mk_b(26'h3FF_FFFE);
        cycle();
        check("b_back_addr", imem_addr, 64'h1F8);
        check("b_back_pred", 64'(if_pred_taken), 64'd1);
        redirect_to(64'h0);
        imem_data = mk_b(26'h3FF_FFFF);
        cycle();
        check("b_wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // Conditional branch: fresh counter, then trained to strongly taken
        redirect_to(64'h300);
        imem_data = mk_bcond(19'h10);
        cycle();
        check("bc_fresh_addr", imem_addr, 64'h304);
        check("bc_fresh_pred", 64'(if_pred_taken), 64'd0);
        imem_data = NOP;
        resolve(64'h300, 1'b1);
        resolve(64'h300, 1'b1);
        redirect_to(64'h300);
        imem_data = mk_bcond(19'h10);
        cycle();
        check("bc_trained_addr", imem_addr, 64'h340);
        check("bc_trained_pred", 64'(if_pred_taken), 64'd1);

        // Not-taken mispredict under stall, then plain stall hold
        stall = 1'b1;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_taken = 1'b0;
        resolve_pc = 64'h400; resolve_target = 64'h777;
        cycle();
        clear_resolve();
        check("mp_stall_addr", imem_addr, 64'h404);
        check("mp_stall_valid", 64'(if_valid), 64'd0);
        check("mp_stall_cnt", 64'(mispredict_count), 64'd5);
        for (int i = 0; i < 3; i++) begin
            imem_data = $urandom();
            cycle();
            check("stall_hold_addr", imem_addr, 64'h404);
        end
        stall = 1'b0;

        // Counter saturation at both ends
        imem_data = NOP;
        for (int i = 0; i < 5; i++) resolve(64'h300, 1'b1);
        resolve(64'h300, 1'b0);
        redirect_to(64'h300);
        imem_data = mk_cbz(19'h20);
        cycle();
        check("sat_hi_pred", 64'(if_pred_taken), 64'd1);
        check("sat_hi_addr", imem_addr, 64'h380);
        imem_data = NOP;
        for (int i = 0; i < 5; i++) resolve(64'h300, 1'b0);
        resolve(64'h300, 1'b1);
        redirect_to(64'h300);
        imem_data = mk_bcond(19'h10);
        cycle();
        check("sat_lo_pred", 64'(if_pred_taken), 64'd0);
        imem_data = NOP;
        for (int i = 0; i < 3; i++) resolve(64'h100, 1'b1);

        // Reset wins over a simultaneous redirect and table update
        reset = 1'b1;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_taken = 1'b1;
        resolve_pc = 64'h100; resolve_target = 64'h999;
        cycle();
        clear_resolve();
        reset = 1'b0;
        check("rst_redir_addr", imem_addr, 64'h100);
        check("rst_redir_cnt", 64'(mispredict_count), 64'd0);
        imem_data = mk_bcond(19'h10);
        cycle();
        check("rst_bht_pred", 64'(if_pred_taken), 64'd0);
        check("rst_bht_addr", imem_addr, 64'h104);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rnd = $urandom();
            case ($urandom_range(0, 4))
                0:       imem_data = mk_b(rnd[25:0]);
                1:       imem_data = mk_bcond(rnd[18:0]);
                2:       imem_data = mk_cbz(rnd[18:0]);
                3:       imem_data = NOP;
                default: imem_data = $urandom();
            endcase
            stall              = ($urandom_range(0, 3) == 0);
            resolve_valid      = ($urandom_range(0, 1) == 1);
            resolve_mispredict = ($urandom_range(0, 4) == 0);
            resolve_taken      = ($urandom_range(0, 1) == 1);
            resolve_pc         = 64'h100 + 64'(4 * $urandom_range(0, 63));
            resolve_target     = {$urandom(), $urandom()};
            reset              = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        clear_resolve();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
